// File: rtl/prime_search_seq.sv
// Sequential next-prime search: returns the smallest prime >= seed using trial division
// by odd divisors, with a single bit-serial restoring divider shared across all divisors.
module prime_search_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prime_out,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = 2 * WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      TEST  = 3'd2,
      DIV   = 3'd3,
      CHK   = 3'd4,
      NEXTC = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] seed_r;
   logic [WIDTH-1:0] cand_r;
   logic [WIDTH:0]   d_r;
   logic [WIDTH:0]   rem_r;
   logic [DW-1:0]    dsq_r;
   logic [CW-1:0]    bit_r;

   logic [WIDTH:0]   init_sum_s;
   logic [WIDTH:0]   next_sum_s;
   logic [WIDTH:0]   shl_s;
   logic [WIDTH:0]   rem_step_s;
   logic [DW-1:0]    dsq_inc_s;
   logic [WIDTH:0]   d_inc_s;
   logic             dsq_gt_s;
   logic             seed_le2_s;

   localparam logic [WIDTH-1:0] TWO_W   = {{(WIDTH-2){1'b0}}, 2'b10};
   localparam logic [WIDTH:0]   THREE_D = {{(WIDTH-1){1'b0}}, 2'b11};
   localparam logic [WIDTH:0]   TWO_D   = {{(WIDTH-1){1'b0}}, 2'b10};
   localparam logic [DW-1:0]    NINE_Q  = {{(DW-4){1'b0}}, 4'b1001};
   localparam logic [DW-1:0]    FOUR_Q  = {{(DW-3){1'b0}}, 3'b100};

   // Datapath helpers: candidate rounding, restoring divide step, divisor-square update.
   always_comb begin
      init_sum_s = {1'b0, seed_r} + {{WIDTH{1'b0}}, ~seed_r[0]};
      next_sum_s = {1'b0, cand_r} + TWO_D;
      shl_s      = {rem_r[WIDTH-1:0], cand_r[bit_r]};
      rem_step_s = (shl_s >= d_r) ? (shl_s - d_r) : shl_s;
      // (d+2)^2 = d^2 + 4d + 4; dsq is wide enough that this never wraps
      dsq_inc_s  = dsq_r + {{(WIDTH-1){1'b0}}, d_r, 2'b00} + FOUR_Q;
      d_inc_s    = d_r + TWO_D;
      dsq_gt_s   = (dsq_r > {{(DW-WIDTH){1'b0}}, cand_r});
      seed_le2_s = (seed_r <= TWO_W);
   end

   // Search FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         seed_r    <= {WIDTH{1'b0}};
         cand_r    <= {WIDTH{1'b0}};
         d_r       <= {(WIDTH+1){1'b0}};
         rem_r     <= {(WIDTH+1){1'b0}};
         dsq_r     <= {DW{1'b0}};
         bit_r     <= {CW{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         prime_out <= {WIDTH{1'b0}};
         overflow  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  seed_r  <= seed;
                  busy    <= 1'b1;
                  state_r <= INIT;
               end
            end
            INIT: begin
               if (seed_le2_s) begin
                  cand_r    <= TWO_W;
                  prime_out <= TWO_W;
                  overflow  <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else if (init_sum_s[WIDTH]) begin
                  cand_r    <= init_sum_s[WIDTH-1:0];
                  prime_out <= {WIDTH{1'b0}};
                  overflow  <= 1'b1;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  cand_r  <= init_sum_s[WIDTH-1:0];
                  d_r     <= THREE_D;
                  dsq_r   <= NINE_Q;
                  state_r <= TEST;
               end
            end
            TEST: begin
               if (dsq_gt_s) begin
                  prime_out <= cand_r;
                  overflow  <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  rem_r   <= {(WIDTH+1){1'b0}};
                  bit_r   <= CW'(WIDTH-1);
                  state_r <= DIV;
               end
            end
            DIV: begin
               rem_r <= rem_step_s;
               if (bit_r == {CW{1'b0}}) begin
                  state_r <= CHK;
               end else begin
                  bit_r <= bit_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            CHK: begin
               if (rem_r == {(WIDTH+1){1'b0}}) begin
                  state_r <= NEXTC;
               end else begin
                  dsq_r   <= dsq_inc_s;
                  d_r     <= d_inc_s;
                  state_r <= TEST;
               end
            end
            NEXTC: begin
               cand_r <= next_sum_s[WIDTH-1:0];
               if (next_sum_s[WIDTH]) begin
                  prime_out <= {WIDTH{1'b0}};
                  overflow  <= 1'b1;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  d_r     <= THREE_D;
                  dsq_r   <= NINE_Q;
                  state_r <= TEST;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prime_search_seq.sv
// Directed bench for prime_search_seq: a 32-bit instance for the main searches and an
// 8-bit instance for the wrap-around overflow boundary.
module tb_prime_search_seq;

   logic        clk;
   logic        rst;
   logic        start32, start8;
   logic [31:0] seed32;
   logic [7:0]  seed8;
   logic        busy32, done32, ovf32;
   logic        busy8, done8, ovf8;
   logic [31:0] prime32;
   logic [7:0]  prime8;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int done_cnt32 = 0;
   int acc32 = 0;
   localparam int LIMIT = 40000;

   prime_search_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .seed(seed32),
      .busy(busy32), .done(done32), .prime_out(prime32), .overflow(ovf32)
   );

   prime_search_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .seed(seed8),
      .busy(busy8), .done(done8), .prime_out(prime8), .overflow(ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses of the 32-bit instance.
   always @(negedge clk) if (done32 === 1'b1) done_cnt32++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int unsigned ref_np(input int unsigned s);
      int unsigned c;
      bit          found;
      if (s <= 2) return 2;
      c = (s % 2 == 0) ? s + 1 : s;
      found = 1'b0;
      while (!found) begin
         found = 1'b1;
         for (int unsigned d = 3; d * d <= c; d += 2) begin
            if (c % d == 0) begin
               found = 1'b0;
               break;
            end
         end
         if (!found) c += 2;
      end
      return c;
   endfunction

   task automatic pulse32(input logic [31:0] s);
      @(negedge clk);
      seed32  = s;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      seed32  = ~s;
   endtask

   task automatic wait32(input string tag);
      int n = 0;
      while (done32 !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done_seen"}, {31'd0, done32}, 32'd1);
   endtask

   task automatic run32(input logic [31:0] s, input logic [31:0] exp, input string tag);
      pulse32(s);
      acc32++;
      chk({tag, " busy_rise"}, {31'd0, busy32}, 32'd1);
      wait32(tag);
      chk({tag, " prime"}, prime32, exp);
      chk({tag, " ovf"}, {31'd0, ovf32}, 32'd0);
      @(negedge clk);
      chk({tag, " done_1cyc"}, {31'd0, done32}, 32'd0);
      chk({tag, " busy_fall"}, {31'd0, busy32}, 32'd0);
   endtask

   task automatic run8(input logic [7:0] s, input logic [7:0] exp, input logic eovf, input string tag);
      int n = 0;
      @(negedge clk);
      seed8  = s;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      seed8  = ~s;
      while (done8 !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done_seen"}, {31'd0, done8}, 32'd1);
      chk({tag, " prime"}, {24'd0, prime8}, {24'd0, exp});
      chk({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eovf});
      @(negedge clk);
      chk({tag, " busy_fall"}, {31'd0, busy8}, 32'd0);
   endtask

   initial begin
      int unsigned rs;
      int          dc;
      rst = 1'b1; start32 = 1'b0; start8 = 1'b0; seed32 = 32'd0; seed8 = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst busy", {31'd0, busy32}, 32'd0);
      chk("rst done", {31'd0, done32}, 32'd0);
      chk("rst prime", prime32, 32'd0);
      chk("rst ovf", {31'd0, ovf32}, 32'd0);
      rst = 1'b0;

      // seed <= 2: done exactly two edges after start is presented
      pulse32(32'd0);
      acc32++;
      chk("s0 busy_rise", {31'd0, busy32}, 32'd1);
      @(negedge clk);
      chk("s0 done_lat", {31'd0, done32}, 32'd1);
      chk("s0 prime", prime32, 32'd2);
      chk("s0 ovf", {31'd0, ovf32}, 32'd0);
      @(negedge clk);
      chk("s0 done_1cyc", {31'd0, done32}, 32'd0);
      pulse32(32'd2);
      acc32++;
      @(negedge clk);
      chk("s2 done_lat", {31'd0, done32}, 32'd1);
      chk("s2 prime", prime32, 32'd2);
      @(negedge clk);

      run32(32'd14, 32'd17, "s14");
      run32(32'd24, 32'd29, "s24");
      run32(32'd1000, 32'd1009, "s1000");
      run32(32'd25, 32'd29, "s25");
      run32(32'd3, 32'd3, "s3");
      run32(32'd9, 32'd11, "s9");

      // start coinciding with done is ignored; result held through idle
      pulse32(32'd17);
      acc32++;
      wait32("s17");
      chk("s17 prime", prime32, 32'd17);
      start32 = 1'b1;
      seed32  = 32'd2;
      @(negedge clk);
      start32 = 1'b0;
      chk("start_at_done busy", {31'd0, busy32}, 32'd0);
      @(negedge clk);
      chk("start_at_done idle", {31'd0, busy32}, 32'd0);
      chk("hold prime", prime32, 32'd17);

      // start while busy is ignored
      pulse32(32'd24);
      acc32++;
      repeat (5) @(negedge clk);
      seed32  = 32'd90;
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      wait32("busy_ign");
      chk("busy_ign prime", prime32, 32'd29);
      @(negedge clk);
      run32(32'd90, 32'd97, "s90");

      // reset in the middle of a divide pass aborts without a done pulse
      pulse32(32'd1000);
      repeat (10) @(negedge clk);
      dc  = done_cnt32;
      rst = 1'b1;
      #1;
      chk("midrst busy", {31'd0, busy32}, 32'd0);
      chk("midrst prime", prime32, 32'd0);
      chk("midrst ovf", {31'd0, ovf32}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("midrst no_done", done_cnt32, dc);
      chk("midrst idle", {31'd0, busy32}, 32'd0);
      run32(32'd8, 32'd11, "s8");

      // 8-bit boundary: candidate wraps past 255
      run8(8'd252, 8'd0, 1'b1, "w8_252");
      run8(8'd251, 8'd251, 1'b0, "w8_251");

      for (int i = 0; i < 2; i++) begin
         rs = $urandom_range(0, 32'h000F_FFFF);
         run32(rs, ref_np(rs), "rand");
      end

      chk("done_per_start", done_cnt32, acc32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
